// File: rtl/main_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : main_controller_pkg
// Purpose : Shared definitions for the multicycle MIPS main control unit:
//           opcode constants, ALUOp codes, mux-select encodings and the
//           controller state enum.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package main_controller_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/main_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : main_ctrl_decode
// Purpose : Combinational state-to-outputs decoder for main_controller.
// Ports   : state      - current controller state
//           op         - opcode (only used to flag illegal opcodes in DECODE)
//           mem_ready  - gates ir_write/pc_write in FETCH
//           rst_n      - while low, all enables/strobes are forced to 0
//           remaining  - datapath control outputs, see main_controller
// Revision: 1.0 - initial release
// ============================================================================
module main_ctrl_decode
  import main_controller_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  input  logic       rst_n,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op
);

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_OP_ADD;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC+4 commit only on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !op_is_legal(op);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNC;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase

    // The state register is already FETCH during reset; suppress its
    // request so nothing leaves the controller until reset is released.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/main_controller.sv
`default_nettype none
// ============================================================================
// Module  : main_controller
// Purpose : Multicycle MIPS main control unit (Moore FSM). Sequences each
//           instruction through fetch/decode/execute/memory/writeback and
//           stalls on the mem_ready handshake.
// Ports   : clk, rst_n (async active-low), op (IR[31:26]), mem_ready
//           mem_req/mem_write      - memory request / store qualifier
//           ir_write/pc_write      - IR load, unconditional PC load
//           branch                 - PC load if ALU zero
//           i_or_d, alu_src_a/b, alu_op, pc_src, reg_dst, mem_to_reg
//                                  - datapath selects
//           reg_write              - register file write
//           illegal_op             - one-cycle pulse on unsupported opcode
// Revision: 1.0 - initial release
// ============================================================================
module main_controller
  import main_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:   if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // op is re-examined here; anything that is no longer a load/store
        // is abandoned rather than guessed at
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   if (mem_ready) state_next = S_FETCH;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  main_ctrl_decode u_decode (
    .state      (state),
    .op         (op),
    .mem_ready  (mem_ready),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op)
  );

endmodule
`default_nettype wire

// File: tb/tb_main_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_main_controller
// Purpose : Self-checking bench for main_controller. Each instruction is
//           described as a list of named steps; a step-level model turns a
//           step name into the full expected output vector, and one compare
//           process checks the DUT against it every cycle. A few literal
//           expectations pin the model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_main_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, mem_write, ir_write, pc_write, branch, i_or_d;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;

  main_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .illegal_op (illegal_op)
  );

  always #10 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [16:0] exp_vec;
  string       exp_name;
  bit          exp_valid = 1'b0;
  bit          rel_next  = 1'b0;
  logic [5:0]  cur_op    = 6'b000000;

  wire [16:0] got_vec = {mem_req, mem_write, ir_write, pc_write, branch,
                         i_or_d, alu_src_a, alu_src_b, alu_op, pc_src,
                         reg_dst, mem_to_reg, reg_write, illegal_op};

  // Step-level model: what every output must be for a named step.
  function automatic logic [16:0] model(input string s, input bit rdy,
                                        input logic [5:0] o);
    logic mreq, mwr, irw, pcw, br, iod, sa, rdst, m2r, rw, ill;
    logic [1:0] sb, aop, ps;
    {mreq, mwr, irw, pcw, br, iod, sa, rdst, m2r, rw, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    if (s == "RESET")        sb = 2'b01;
    else if (s == "FETCH")   begin mreq = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
    else if (s == "DECODE")  begin
      sb  = 2'b11;
      ill = !(o inside {6'b000000, 6'b100011, 6'b101011,
                        6'b000100, 6'b001000, 6'b000010});
    end
    else if (s == "MEMADR")  begin sa = 1; sb = 2'b10; end
    else if (s == "MEMRD")   begin mreq = 1; iod = 1; end
    else if (s == "MEMWB")   begin m2r = 1; rw = 1; end
    else if (s == "MEMWR")   begin mreq = 1; mwr = 1; iod = 1; end
    else if (s == "EXECUTE") begin sa = 1; aop = 2'b10; end
    else if (s == "ALUWB")   begin rdst = 1; rw = 1; end
    else if (s == "BRANCH")  begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
    else if (s == "ADDIEX")  begin sa = 1; sb = 2'b10; end
    else if (s == "ADDIWB")  rw = 1;
    else if (s == "JUMP")    begin ps = 2'b10; pcw = 1; end
    return {mreq, mwr, irw, pcw, br, iod, sa, sb, aop, ps, rdst, m2r, rw, ill};
  endfunction

  // Single per-cycle compare process.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_valid) begin
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL step_%s cyc=%0d got=%b exp=%b", exp_name, cyc, got_vec, exp_vec);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, req);
    end
  endtask

  // Hand-computed literal expectations for selected steps.
  task automatic pins(input string s);
    if (s == "RESET") begin
      lit("rst_mem_req", {7'd0, mem_req}, 8'd0);
      lit("rst_strobes", {2'd0, mem_write, ir_write, pc_write, branch, reg_write, illegal_op}, 8'd0);
      lit("rst_srcb", {6'd0, alu_src_b}, 8'd1);
    end
    else if (s == "EXECUTE") lit("exec_alu_op", {6'd0, alu_op}, 8'b10);
    else if (s == "ALUWB")   lit("aluwb_wr_dst", {6'd0, reg_write, reg_dst}, 8'b11);
    else if (s == "MEMWB")   lit("memwb_m2r_wr_dst", {5'd0, mem_to_reg, reg_write, reg_dst}, 8'b110);
    else if (s == "BRANCH")  lit("beq_op_src_br", {3'd0, alu_op, pc_src, branch}, 8'b01011);
    else if (s == "JUMP")    lit("j_src_pcw", {5'd0, pc_src, pc_write}, 8'b101);
    else if (s == "DECODE" && cur_op == 6'b111111)
      lit("illegal_pulse", {5'd0, illegal_op, reg_write, mem_write}, 8'b100);
  endtask

  // One cycle: inputs change 1 after the rising edge, literals checked at +3,
  // the compare process samples on the falling edge.
  task automatic do_cycle(input string s, input bit rdy);
    bit released;
    @(posedge clk); #1;
    released = rel_next;
    if (rel_next) begin rst_n = 1'b1; rel_next = 1'b0; end
    mem_ready = rdy;
    // op is only meaningful in DECODE/MEMADR; elsewhere drive a different
    // legal opcode that must be ignored
    if (s == "DECODE" || s == "MEMADR") op = cur_op;
    else op = (cur_op == 6'b000010) ? 6'b000000 : 6'b000010;
    exp_vec   = model(s, rdy, cur_op);
    exp_name  = s;
    exp_valid = 1'b1;
    #2;
    pins(s);
    if (released) lit("post_rst_fetch", {6'd0, ir_write, pc_write}, 8'b11);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) do_cycle("RESET", 1'b1);
    rel_next = 1'b1;
  endtask

  // Drop reset mid-cycle and require the strobes to fall at once.
  task automatic do_abort();
    #2;
    rst_n     = 1'b0;
    exp_vec   = model("RESET", 1'b1, cur_op);
    exp_name  = "RESET";
    #1;
    lit("abort_req_wr", {6'd0, mem_req, mem_write}, 8'd0);
  endtask

  // fw/mw: wait cycles in fetch / data memory; abort_at: index of the
  // data-memory wait cycle in which reset is dropped (-1 = never).
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw,
                           input int abort_at);
    cur_op = o;
    for (int i = 0; i < fw; i++) do_cycle("FETCH", 1'b0);
    do_cycle("FETCH", 1'b1);
    do_cycle("DECODE", 1'b1);
    case (o)
      6'b100011: begin
        do_cycle("MEMADR", 1'b1);
        for (int i = 0; i < mw; i++) do_cycle("MEMRD", 1'b0);
        do_cycle("MEMRD", 1'b1);
        do_cycle("MEMWB", 1'b1);
      end
      6'b101011: begin
        do_cycle("MEMADR", 1'b1);
        for (int i = 0; i < mw; i++) begin
          do_cycle("MEMWR", 1'b0);
          if (i == abort_at) begin do_abort(); return; end
        end
        do_cycle("MEMWR", 1'b1);
      end
      6'b000000: begin do_cycle("EXECUTE", 1'b1); do_cycle("ALUWB", 1'b1); end
      6'b000100: do_cycle("BRANCH", 1'b1);
      6'b001000: begin do_cycle("ADDIEX", 1'b1); do_cycle("ADDIWB", 1'b1); end
      6'b000010: do_cycle("JUMP", 1'b1);
      default: ;
    endcase
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    op        = 6'b000000;
    do_reset(3);
    run_instr(6'b000000, 0, 0, -1);   // R-type, mem_ready tied high
    run_instr(6'b100011, 0, 2, -1);   // lw, 2 wait cycles in MEMRD
    run_instr(6'b101011, 1, 0, -1);   // sw, 1 fetch wait
    run_instr(6'b000100, 0, 0, -1);   // beq
    run_instr(6'b000010, 0, 0, -1);   // j
    run_instr(6'b001000, 2, 0, -1);   // addi, 2 fetch waits
    run_instr(6'b111111, 0, 0, -1);   // illegal
    run_instr(6'b100011, 0, 0, -1);   // lw, zero wait
    run_instr(6'b101011, 0, 3, 1);    // sw aborted by reset during wait
    do_reset(2);
    run_instr(6'b000000, 0, 0, -1);   // R-type right after release
    run_instr(6'b000001, 0, 0, -1);   // another illegal opcode
    run_instr(6'b101011, 0, 1, -1);   // sw, one wait
    @(posedge clk); #1;
    exp_valid = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
